// File: rtl/metric_mem_pkg.sv
// Shared defaults, FSM encoding and helpers for the ping-pong path-metric memory.
package metric_mem_pkg;

    localparam int WD_METR_DEF = 8;
    localparam int N_ACS_DEF   = 4;
    localparam int N_ITER_DEF  = 64;
    localparam int LANE_MAX_W  = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Callers zero-extend narrower metrics and truncate the result back.
    function automatic logic [LANE_MAX_W-1:0] lane_min(input logic [LANE_MAX_W-1:0] a,
                                                       input logic [LANE_MAX_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/metric_bank.sv
// One metric bank: flop array with single write port and a pair-read port
// returning {word[2a+1], word[2a]}. Flops update on the falling clock edge.
module metric_bank
    import metric_mem_pkg::*;
#(
    parameter int WD     = WD_METR_DEF * N_ACS_DEF,
    parameter int N_ITER = N_ITER_DEF,
    parameter int AW     = $clog2(N_ITER)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [WD-1:0] wdata,
    input  logic [AW-2:0] raddr,
    output logic [2*WD-1:0] rdata
);

    logic [WD-1:0] mem [N_ITER];

    // NOTE: the array is built from flops, so it can take an async clear; a
    // RAM macro could not, and resetting it would block RAM inference.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ITER; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = {mem[{raddr, 1'b1}], mem[{raddr, 1'b0}]};

endmodule

// File: rtl/metric_pingpong_mem.sv
// Ping-pong path-metric store between the ACS array and the path-metric mux:
// one bank is filled per trellis stage while the other is read, normalised.
module metric_pingpong_mem
    import metric_mem_pkg::*;
#(
    parameter int WD_METR = WD_METR_DEF,
    parameter int N_ACS   = N_ACS_DEF,
    parameter int N_ITER  = N_ITER_DEF,
    parameter int AW      = $clog2(N_ITER),
    parameter int NORM_EN = 1
) (
    input  logic                         Clock1,
    input  logic                         Reset,
    input  logic                         Active,
    input  logic                         StartFrame,
    input  logic                         MMWriteValid,
    input  logic [AW-1:0]                MMWriteAddress,
    input  logic [WD_METR*N_ACS-1:0]     MMMetric,
    input  logic                         MMReadValid,
    input  logic [AW-2:0]                MMReadAddress,
    output logic [2*WD_METR*N_ACS-1:0]   MMPathMetric,
    output logic                         MMPathValid,
    output logic                         MMBlockSelect,
    output logic                         SwapDone,
    output logic                         MMOverwrite
);

    localparam int WW = WD_METR * N_ACS;
    localparam int PW = 2 * WW;

    state_e              state, state_next;
    logic                frame_start, wr_accept, rd_accept, stage_done;
    logic [AW-1:0]       wr_cnt;
    logic [N_ITER-1:0]   written;
    logic [WD_METR-1:0]  min_track, write_min, norm_offset;
    logic [PW-1:0]       pair_a, pair_b, rd_pair, norm_pair;

    // Every flop in this block is clocked on the falling edge of Clock1.
    always_ff @(negedge Clock1 or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: combinational blocks use blocking '=' and assign a default first,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        if (Active && StartFrame) state_next = RUN;
    end

    // StartFrame outranks a same-edge write; writes need RUN, reads do not.
    always_comb begin
        frame_start = Active && StartFrame;
        wr_accept   = (state == RUN) && Active && MMWriteValid && !StartFrame;
        rd_accept   = Active && MMReadValid;
    end

    assign stage_done = wr_accept && (wr_cnt == AW'(N_ITER - 1));

    // Running stage minimum, including the lanes of the current write.
    always_comb begin
        write_min = min_track;
        for (int i = 0; i < N_ACS; i++) begin
            write_min = WD_METR'(lane_min(LANE_MAX_W'(write_min),
                                          LANE_MAX_W'(MMMetric[i*WD_METR +: WD_METR])));
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(negedge Clock1 or negedge Reset) begin
        if (!Reset) begin
            wr_cnt        <= '0;
            written       <= '0;
            MMBlockSelect <= 1'b0;
            min_track     <= '1;
            norm_offset   <= '0;
            SwapDone      <= 1'b0;
            MMOverwrite   <= 1'b0;
        end else begin
            SwapDone <= stage_done;
            if (frame_start) begin
                wr_cnt        <= '0;
                written       <= '0;
                MMBlockSelect <= 1'b0;
                min_track     <= '1;
                norm_offset   <= '0;
                MMOverwrite   <= 1'b0;
            end else if (wr_accept) begin
                if (written[MMWriteAddress]) MMOverwrite <= 1'b1;
                if (stage_done) begin
                    wr_cnt        <= '0;
                    written       <= '0;
                    MMBlockSelect <= ~MMBlockSelect;
                    min_track     <= '1;
                    norm_offset   <= (NORM_EN != 0) ? write_min : '0;
                end else begin
                    wr_cnt                  <= wr_cnt + 1'b1;
                    written[MMWriteAddress] <= 1'b1;
                    min_track               <= write_min;
                end
            end
        end
    end

    metric_bank #(.WD(WW), .N_ITER(N_ITER), .AW(AW)) u_bank_a (
        .clk   (Clock1),
        .rst_n (Reset),
        .we    (wr_accept && !MMBlockSelect),
        .waddr (MMWriteAddress),
        .wdata (MMMetric),
        .raddr (MMReadAddress),
        .rdata (pair_a)
    );

    metric_bank #(.WD(WW), .N_ITER(N_ITER), .AW(AW)) u_bank_b (
        .clk   (Clock1),
        .rst_n (Reset),
        .we    (wr_accept && MMBlockSelect),
        .waddr (MMWriteAddress),
        .wdata (MMMetric),
        .raddr (MMReadAddress),
        .rdata (pair_b)
    );

    // Read the bank not being written; the offset is that bank's minimum.
    assign rd_pair = MMBlockSelect ? pair_a : pair_b;

    always_comb begin
        norm_pair = rd_pair;
        for (int i = 0; i < 2 * N_ACS; i++) begin
            norm_pair[i*WD_METR +: WD_METR] = rd_pair[i*WD_METR +: WD_METR] - norm_offset;
        end
    end

    always_ff @(negedge Clock1 or negedge Reset) begin
        if (!Reset) begin
            MMPathMetric <= '0;
            MMPathValid  <= 1'b0;
        end else begin
            MMPathValid <= rd_accept;
            if (rd_accept) MMPathMetric <= norm_pair;
        end
    end

endmodule
